// File: rtl/comp.sv
// comp -- pipelined unsigned multiply-accumulate unit.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset; clears every register
//   i_param    in   [p_size-1:0]    unsigned operand A
//   i_param_2  in   [p_size-1:0]    unsigned operand B
//   ena        in   sample strobe; operands are captured on an edge with ena=1
//   o_param    out  [2*p_size-1:0]  product of the most recently completed sample
//   o_param_2  out  [2*p_size-1:0]  running sum of all completed products
//   dv         out  one-cycle pulse per completed sample
//
// Timing: a sample captured at edge N shows up on the outputs, with dv=1,
// after edge N+2.  Stage 1 holds the operands.  Stage 2 is split into a
// multiply register and an output register.  The output register loads the
// product and updates the accumulator on the same edge.  One sample can be
// accepted every cycle.
//
// Build option: define COMP_ACC_SAT_EN to make the accumulator saturate at
// all-ones.  Once it saturates, it stays there until reset.  Without the
// macro, the accumulator wraps modulo 2^(2*p_size).

module comp #(
    parameter int p_size = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [p_size-1:0]     i_param,
    input  logic [p_size-1:0]     i_param_2,
    input  logic                  ena,
    output logic [2*p_size-1:0]   o_param,
    output logic [2*p_size-1:0]   o_param_2,
    output logic                  dv
);

    localparam int acc_w = 2 * p_size;

    logic [p_size-1:0] a_q, a_d;
    logic [p_size-1:0] b_q, b_d;
    logic              v1_q, v1_d;
    logic [acc_w-1:0]  prod_q, prod_d;
    logic              v2_q, v2_d;
    logic [acc_w-1:0]  res_q, res_d;
    logic [acc_w-1:0]  acc_q, acc_d;
    logic              dv_q, dv_d;
`ifdef COMP_ACC_SAT_EN
    logic [acc_w:0]    acc_sum;
`endif

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        v1_d   = ena;
        prod_d = prod_q;
        v2_d   = v1_q;
        res_d  = res_q;
        acc_d  = acc_q;
        dv_d   = v2_q;
`ifdef COMP_ACC_SAT_EN
        acc_sum = {1'b0, acc_q} + {1'b0, prod_q};
`endif

        // Operands are held while ena is low. Input changes made in idle
        // cycles therefore never reach the datapath.
        if (ena) begin
            a_d = i_param;
            b_d = i_param_2;
        end

        // Zero-extend both operands first, so that the product is formed
        // at full width.
        if (v1_q) begin
            prod_d = {{p_size{1'b0}}, a_q} * {{p_size{1'b0}}, b_q};
        end

        if (v2_q) begin
            res_d = prod_q;
`ifdef COMP_ACC_SAT_EN
            // A carry out of the top bit means the true sum has overflowed.
            // An accumulator already at all-ones stays there, because
            // products are never negative.
            acc_d = acc_sum[acc_w] ? {acc_w{1'b1}} : acc_sum[acc_w-1:0];
`else
            acc_d = acc_q + prod_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            v1_q   <= 1'b0;
            prod_q <= '0;
            v2_q   <= 1'b0;
            res_q  <= '0;
            acc_q  <= '0;
            dv_q   <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            v1_q   <= v1_d;
            prod_q <= prod_d;
            v2_q   <= v2_d;
            res_q  <= res_d;
            acc_q  <= acc_d;
            dv_q   <= dv_d;
        end
    end

    assign o_param   = res_q;
    assign o_param_2 = acc_q;
    assign dv        = dv_q;

endmodule

// File: tb/tb_comp.sv
module tb_comp;

    logic       clk;
    logic       rst;
    logic [3:0] a, b;
    logic       ena;
    logic [7:0] o_p, o_acc;
    logic       dv;

    logic       a1, b1, e1;
    logic [1:0] o_p1, o_acc1;
    logic       dv1;

    int n_chk;
    int n_err;

    comp #(.p_size(4)) dut (
        .clk(clk), .rst(rst), .i_param(a), .i_param_2(b), .ena(ena),
        .o_param(o_p), .o_param_2(o_acc), .dv(dv)
    );

    comp dut1 (
        .clk(clk), .rst(rst), .i_param(a1), .i_param_2(b1), .ena(e1),
        .o_param(o_p1), .o_param_2(o_acc1), .dv(dv1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef COMP_ACC_SAT_EN
    localparam logic [7:0] acc_ovf_exp = 8'd255;
`else
    localparam logic [7:0] acc_ovf_exp = 8'd4;
`endif

    // Reference model: every accepted edge pushes a sample into a queue.
    // A sample completes two edges later, when it leaves the queue.
    typedef struct {
        bit          v;
        int unsigned p;
    } slot_t;
    slot_t       pipe[$];
    int unsigned m_p, m_acc;
    bit          m_dv;

    task automatic model_clear();
        pipe.delete();
        m_p   = 0;
        m_acc = 0;
        m_dv  = 0;
    endtask

    task automatic model_edge(input int unsigned ma, input int unsigned mb, input bit me);
        slot_t s;
        int unsigned sum;
        pipe.push_back('{v: me, p: ma * mb});
        m_dv = 0;
        if (pipe.size() > 2) begin
            s = pipe.pop_front();
            if (s.v) begin
                m_p  = s.p;
                m_dv = 1;
                sum  = m_acc + s.p;
`ifdef COMP_ACC_SAT_EN
                m_acc = (sum > 255) ? 255 : sum;
`else
                m_acc = sum % 256;
`endif
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Applies one edge to the 4-bit instance. If r=0, rst is held low across
    // the edge. The outputs are compared against the model 1 time unit
    // after the edge.
    task automatic tick(input logic [3:0] ta, input logic [3:0] tb, input bit te, input bit r);
        a   = ta;
        b   = tb;
        ena = te;
        rst = r;
        @(posedge clk);
        if (!r) model_clear();
        else    model_edge(ta, tb, te);
        #1;
        chk("model o_param",   o_p,   m_p);
        chk("model o_param_2", o_acc, m_acc);
        chk("model dv",        dv,    m_dv);
    endtask

    typedef struct {
        bit         rs;
        logic [3:0] a;
        logic [3:0] b;
        bit         e;
        logic [7:0] ep;
        logic [7:0] ea;
        bit         edv;
    } vec_t;
    vec_t vt[14];

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b0; a = '0; b = '0; ena = 1'b0;
        a1 = 1'b0; b1 = 1'b0; e1 = 1'b0;
        model_clear();

        // Single sample, then back-to-back samples and accumulator overflow
        vt[0]  = '{1, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 3, 5, 1, 0, 0, 0};
        vt[2]  = '{0, 7, 7, 0, 0, 0, 0};
        vt[3]  = '{0, 1, 2, 0, 15, 15, 1};
        vt[4]  = '{0, 6, 6, 0, 15, 15, 0};
        vt[5]  = '{0, 9, 9, 0, 15, 15, 0};
        vt[6]  = '{1, 0, 0, 0, 0, 0, 0};
        vt[7]  = '{0, 2, 7, 1, 0, 0, 0};
        vt[8]  = '{0, 15, 15, 1, 0, 0, 0};
        vt[9]  = '{0, 1, 1, 1, 14, 14, 1};
        vt[10] = '{0, 4, 5, 1, 225, 239, 1};
        vt[11] = '{0, 0, 0, 0, 1, 240, 1};
        vt[12] = '{0, 9, 9, 0, 20, acc_ovf_exp, 1};
        vt[13] = '{0, 3, 3, 0, 20, acc_ovf_exp, 0};

        // Reset held low with random inputs and ena toggling
        for (int i = 0; i < 8; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); e1 = 1'(i % 2);
            tick(4'($urandom), 4'($urandom), bit'(i % 2), 0);
            chk("reset o_param", o_p, 0);
            chk("reset o_param_2", o_acc, 0);
            chk("reset dv", dv, 0);
            chk("reset p1 dv", dv1, 0);
        end
        e1 = 1'b0;

        for (int i = 0; i < 14; i++) begin
            tick(vt[i].a, vt[i].b, vt[i].e, !vt[i].rs);
            chk($sformatf("vec%0d o_param", i),   o_p,   vt[i].ep);
            chk($sformatf("vec%0d o_param_2", i), o_acc, vt[i].ea);
            chk($sformatf("vec%0d dv", i),        dv,    vt[i].edv);
        end

        // Reset mid-flight: the sample that was in flight must be flushed
        tick(0, 0, 0, 0);
        tick(3, 3, 1, 1);
        tick(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 1);
            chk("flush dv", dv, 0);
            chk("flush o_param", o_p, 0);
            chk("flush o_param_2", o_acc, 0);
        end
        tick(2, 2, 1, 1);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        chk("post-reset o_param", o_p, 4);
        chk("post-reset o_param_2", o_acc, 4);
        chk("post-reset dv", dv, 1);

        // Width 1: all four operand combinations back-to-back
        tick(0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                a1 = k[1];
                b1 = k[0];
                e1 = 1'b1;
            end else begin
                e1 = 1'b0;
            end
            tick(0, 0, 0, 1);
            if (k >= 2) begin
                chk("p1 dv", dv1, 1);
                chk("p1 o_param", o_p1, (k == 5) ? 1 : 0);
                chk("p1 o_param_2", o_acc1, (k == 5) ? 1 : 0);
            end else begin
                chk("p1 early dv", dv1, 0);
            end
        end
        tick(0, 0, 0, 1);
        chk("p1 idle dv", dv1, 0);
        chk("p1 final o_param_2", o_acc1, 1);

        // Random traffic with occasional reset pulses
        tick(0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            tick(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 49) != 0));
        end

        // Asynchronous reset must clear the outputs without a clock edge
        tick(0, 0, 0, 0);
        tick(5, 5, 1, 1);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        chk("pre-async o_param", o_p, 25);
        rst = 1'b0;
        #2;
        chk("async o_param", o_p, 0);
        chk("async o_param_2", o_acc, 0);
        chk("async dv", dv, 0);
        tick(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
